array_operand_loader: RTL
=========================

// Module: array_operand_loader
// PURPOSE
//  Stage directly upstream of the flat-array adder. Collects NUM_ELEMS serial
//   elements into operand A, then NUM_ELEMS more into operand B, using a
//   valid/ready input stream. Then presents both flat arrays together on a
//   valid/ready output that drives the adder's flatArray1/flatArray2 inputs.
//  Single-buffered: input is stalled while a loaded pair waits to be taken.
// PARAMETERS
//  ELEM_W     3  bits per array element
//  NUM_ELEMS  9  elements per operand; ARRAY_W = ELEM_W*NUM_ELEMS (27) is a localparam
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous reset, active-low
//  clear        in   1        synchronous abort: discard any partial or held pair
//  in_valid     in   1        in_data is valid
//  in_ready     out  1        loader accepts an element this cycle
//  in_data      in   ELEM_W   element value
//  in_last      in   1        framing marker; used only with ARRAY_LOADER_LAST_CHECK_EN
//  out_valid    out  1        flat_array1/flat_array2 hold a complete pair
//  out_ready    in   1        consumer takes the pair this cycle
//  flat_array1  out  ARRAY_W  operand A; element i at bits [i*ELEM_W +: ELEM_W]
//  flat_array2  out  ARRAY_W  operand B; same packing as operand A
//  frame_err    out  1        sticky framing error (0 when the feature is compiled out)
// BEHAVIOUR
//  Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
//  Reset values: state=LOAD_A, idx=0, flat_array1=0, flat_array2=0, out_valid=0, frame_err=0.
//  Reset mid-load: any partially loaded data is discarded.
//  States:
//   - LOAD_A: in_ready=1. Each transfer (in_valid & in_ready) writes in_data to element idx of A.
//     idx increments; at idx=NUM_ELEMS-1 it wraps to 0 and the state moves to LOAD_B.
//   - LOAD_B: same as LOAD_A, but writes into B. The last element moves the state to PRESENT.
//   - PRESENT: in_ready=0 and out_valid=1. Outputs stay stable until out_ready=1.
//     When out_ready=1, the next state is LOAD_A and out_valid drops the following cycle.
//  in_ready is a combinational decode of state only; it never depends on in_valid.
//  out_valid is registered. Minimum latency is 1 cycle from the last B transfer to out_valid=1.
//   A back-to-back stream gives 2*NUM_ELEMS+1 cycles per pair (input stalls 1 cycle in PRESENT).
//  Outputs in LOAD states keep their previous values.
//   Elements not yet overwritten stay stale and are not zeroed between pairs.
//  idx counter width is $clog2(NUM_ELEMS); it must never reach NUM_ELEMS.
//  clear: next state LOAD_A, idx=0, out_valid=0. Array contents are untouched.
//   If clear and a transfer occur in the same cycle, clear wins and the element is dropped.
//   If clear and out_ready occur together in PRESENT, the pair counts as consumed (no duplicate).
//  in_valid=1 while in PRESENT has no effect; in_data is not captured.
// CONFIGURATION
//  ARRAY_LOADER_LAST_CHECK_EN defined:
//   - in_last must be 1 exactly on the final B element.
//   - in_last=1 on any other transfer, or 0 on the final B element, sets frame_err (sticky).
//   - A mismatch also resyncs: next state LOAD_A, idx=0, no PRESENT.
//   - frame_err is cleared only by rst_n or clear.
//  Not defined: in_last is ignored, frame_err is tied to 0, and the FSM is unchanged.
// STRUCTURE
//  array_pkg: ELEM_W/NUM_ELEMS defaults, state enum {LOAD_A,LOAD_B,PRESENT},
//   and an idx width function. Shared with the adder and its bench.
//  Sub-module flat_array_packer (x2, one per operand): per-element write-enable register
//   of ARRAY_W bits with inputs wr_en, idx, data.
//  Top level holds the FSM, the idx counter, the handshake and the frame check.
// TESTING
//  1. Reset, then stream A=0,7,6,5,4,3,2,1,0 and B=1 x9 with no gaps
//     -> out_valid after 19 cycles; flat_array1=27'o012345670, flat_array2=27'o111111111.
//  2. Hold out_ready=0 for 5 cycles in PRESENT with in_valid=1 -> in_ready=0 and outputs
//     stable throughout. Then out_ready=1 -> out_valid=0 next cycle and in_ready=1.
//  3. Assert clear after 4 A elements, then send a full pair of all-7 elements
//     -> out_valid once; flat_array1=flat_array2=27'o777777777.
//  4. Assert rst_n low mid-LOAD_B, asynchronously between clock edges
//     -> all outputs 0 immediately; a following full pair loads correctly.
//  5. Random in_valid gaps and out_ready backpressure over 100 pairs
//     -> every pair matches the scoreboard, with no dropped or duplicated elements.
//  6. LAST_CHECK_EN: in_last on the 5th A element -> frame_err=1 and state LOAD_A;
//     the next correct pair presents while frame_err stays 1.

Source files
------------

// File: rtl/array_pkg.sv
// array_pkg: shared defaults and state encoding for the flat-array operand
// loader, the flat-array adder and their benches.
package array_pkg;

    localparam int ELEM_W_DEF    = 3;
    localparam int NUM_ELEMS_DEF = 9;

    // Loader sequencing: fill A, fill B, then hold the pair for the adder.
    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } loaderState_e;

    // Width of an element index counter; never less than one bit.
    function automatic int idxWidth(input int numElems);
        return (numElems > 1) ? $clog2(numElems) : 1;
    endfunction

endpackage

// File: rtl/flat_array_packer.sv
// flat_array_packer: one operand register of NUM_ELEMS elements. A write
// replaces only the element selected by idx; all other elements keep their
// previous (possibly stale) contents.
module flat_array_packer
    import array_pkg::*;
#(
    parameter  int ELEM_W    = ELEM_W_DEF,
    parameter  int NUM_ELEMS = NUM_ELEMS_DEF,
    parameter  int IDX_W     = idxWidth(NUM_ELEMS),
    localparam int ARRAY_W   = ELEM_W * NUM_ELEMS
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   idx,
    input  logic [ELEM_W-1:0]  data,
    output logic [ARRAY_W-1:0] flat_array
);

    // Per-element write enable decoded from idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flat_array <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                if (idx == IDX_W'(i)) begin
                    flat_array[i*ELEM_W +: ELEM_W] <= data;
                end
            end
        end
    end

endmodule

// File: rtl/array_operand_loader.sv
// array_operand_loader: gathers NUM_ELEMS serial elements into operand A,
// NUM_ELEMS more into operand B, then presents both flat arrays to the
// flat-array adder on a valid/ready output. Single-buffered: the input
// stream stalls while a complete pair waits to be taken.
// Optional feature macro: ARRAY_LOADER_LAST_CHECK_EN enables in_last framing
// checks with a sticky frame_err and a resync to LOAD_A on a mismatch.
module array_operand_loader
    import array_pkg::*;
#(
    parameter  int ELEM_W    = ELEM_W_DEF,
    parameter  int NUM_ELEMS = NUM_ELEMS_DEF,
    localparam int ARRAY_W   = ELEM_W * NUM_ELEMS
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ELEM_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ARRAY_W-1:0] flat_array1,
    output logic [ARRAY_W-1:0] flat_array2,
    output logic               frame_err
);

    localparam int IDX_W = idxWidth(NUM_ELEMS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

    localparam logic [1:0] ST_LOAD_A  = LOAD_A;
    localparam logic [1:0] ST_LOAD_B  = LOAD_B;
    localparam logic [1:0] ST_PRESENT = PRESENT;

    logic [1:0]       state;
    logic [1:0]       nextState;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] nextIdx;
    logic             outValidQ;
    logic             xfer;
    logic             lastElem;
    logic             finalB;
    logic             lastErr;
    logic             wrA;
    logic             wrB;

    // Input readiness depends on state only; clear suppresses the transfer
    // so an element arriving together with clear is dropped.
    assign in_ready = (state != ST_PRESENT);
    assign xfer     = in_valid & in_ready & ~clear;
    assign lastElem = (idx == LAST_IDX);
    assign finalB   = (state == ST_LOAD_B) & lastElem;

    assign wrA = xfer & (state == ST_LOAD_A);
    assign wrB = xfer & (state == ST_LOAD_B);

`ifdef ARRAY_LOADER_LAST_CHECK_EN
    logic frameErrQ;

    // in_last must mark exactly the final B element; anything else is a
    // framing error that also forces a resync.
    assign lastErr = xfer & (in_last != finalB);

    // Sticky framing error, cleared only by reset or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frameErrQ <= 1'b0;
        end else if (clear) begin
            frameErrQ <= 1'b0;
        end else if (lastErr) begin
            frameErrQ <= 1'b1;
        end
    end

    assign frame_err = frameErrQ;
`else
    logic unusedLast;

    assign unusedLast = in_last;
    assign lastErr    = 1'b0;
    assign frame_err  = 1'b0;
`endif

    // Next-state and index decode; clear overrides everything, and a
    // consumed pair returns to LOAD_A whether or not clear is also high.
    always_comb begin
        nextState = state;
        nextIdx   = idx;
        if (clear) begin
            nextState = ST_LOAD_A;
            nextIdx   = '0;
        end else begin
            case (state)
                ST_LOAD_A, ST_LOAD_B: begin
                    if (xfer) begin
                        if (lastErr) begin
                            nextState = ST_LOAD_A;
                            nextIdx   = '0;
                        end else if (lastElem) begin
                            nextIdx   = '0;
                            nextState = (state == ST_LOAD_A) ? ST_LOAD_B : ST_PRESENT;
                        end else begin
                            nextIdx = idx + 1'b1;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        nextState = ST_LOAD_A;
                    end
                end
                default: begin
                    nextState = ST_LOAD_A;
                    nextIdx   = '0;
                end
            endcase
        end
    end

    // State, index and registered out_valid (high exactly while in PRESENT).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD_A;
            idx       <= '0;
            outValidQ <= 1'b0;
        end else begin
            state     <= nextState;
            idx       <= nextIdx;
            outValidQ <= (nextState == ST_PRESENT);
        end
    end

    assign out_valid = outValidQ;

    flat_array_packer #(
        .ELEM_W    (ELEM_W),
        .NUM_ELEMS (NUM_ELEMS),
        .IDX_W     (IDX_W)
    ) uPackerA (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wrA),
        .idx        (idx),
        .data       (in_data),
        .flat_array (flat_array1)
    );

    flat_array_packer #(
        .ELEM_W    (ELEM_W),
        .NUM_ELEMS (NUM_ELEMS),
        .IDX_W     (IDX_W)
    ) uPackerB (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wrB),
        .idx        (idx),
        .data       (in_data),
        .flat_array (flat_array2)
    );

endmodule
